// File: rtl/rf_sb_if.sv
// Issue/writeback bundle between the decode/issue stage and the register-file hazard scoreboard.
// The master drives the issue and writeback requests. The slave returns the stall decision and the status.
interface rf_sb_if #(
  parameter int CNT_W = 3
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_rd_we;
  logic             id_long;
  logic             flush;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             stall;
  logic             issue_fire;
  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] outstanding;
  logic             err;
  logic [31:0]      stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_long,
           flush, wb_valid, wb_rd,
    input  stall, issue_fire, busy_vec, outstanding, err, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_long,
           flush, wb_valid, wb_rd,
    output stall, issue_fire, busy_vec, outstanding, err, stall_cycles
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Scoreboard for long-latency ops that stalls issue on RAW/WAW hazards and on a full outstanding budget.
// Define RF_SB_STATS_EN to build the stall-cycle counter. Without it, stall_cycles is tied to zero.
module rf_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input logic    clk,
  input logic    rst,
  rf_sb_if.slave sb
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;

  logic [31:0] clr_mask, set_mask, eff_busy;
  logic        raw, waw, full, stall, fire, inc, dec, underflow, stray_wb;

  // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (sb.wb_valid && sb.wb_rd != 5'd0) clr_mask[sb.wb_rd] = 1'b1;
    // A writeback frees its register in the same cycle, as the regfile writes through.
    eff_busy = busy_q & ~clr_mask;

    raw   = (sb.id_rs1_used && eff_busy[sb.id_rs1]) || (sb.id_rs2_used && eff_busy[sb.id_rs2]);
    waw   = sb.id_rd_we && eff_busy[sb.id_rd];
    full  = sb.id_long && (outstanding_q == MAX_CNT);
    stall = sb.id_valid && !sb.flush && (raw || waw || full);
    fire  = sb.id_valid && !sb.flush && !stall;

    if (fire && sb.id_long && sb.id_rd_we && sb.id_rd != 5'd0) set_mask[sb.id_rd] = 1'b1;
    busy_d = eff_busy | set_mask;

    inc       = fire && sb.id_long;
    dec       = sb.wb_valid;
    underflow = dec && !inc && (outstanding_q == '0);
    stray_wb  = sb.wb_valid && sb.wb_rd != 5'd0 && !busy_q[sb.wb_rd];

    outstanding_d = outstanding_q;
    if (inc && !dec)                    outstanding_d = outstanding_q + CNT_W'(1);
    else if (dec && !inc && !underflow) outstanding_d = outstanding_q - CNT_W'(1);

    err_d = err_q || underflow || stray_wb;
  end

  // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

`ifdef RF_SB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign sb.stall_cycles = stall_cnt_q;
`else
  assign sb.stall_cycles = 32'd0;
`endif

  assign sb.stall       = stall;
  assign sb.issue_fire  = fire;
  assign sb.busy_vec    = busy_q;
  assign sb.outstanding = outstanding_q;
  assign sb.err         = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard using hand-computed expectations.
// It covers reset, RAW bypass, WAW with set-wins, the budget limit, x0 and flush, error conditions and stats.
module tb_rf_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rf_sb_if #(.CNT_W(3)) sb();
  rf_scoreboard #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .sb(sb));

  always #5 clk = ~clk;

`ifdef RF_SB_STATS_EN
  localparam logic [31:0] EXP_STALLS = 32'd3;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb.id_valid = 0; sb.id_rs1 = 0; sb.id_rs2 = 0; sb.id_rs1_used = 0; sb.id_rs2_used = 0;
    sb.id_rd = 0; sb.id_rd_we = 0; sb.id_long = 0; sb.flush = 0; sb.wb_valid = 0; sb.wb_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic is_long);
    idle();
    sb.id_valid = 1; sb.id_rd = rd; sb.id_rd_we = 1; sb.id_long = is_long;
  endtask

  task automatic state(input string tag, input logic [31:0] busy, input logic [31:0] outs,
                       input logic [31:0] e);
    chk({tag, ".busy"}, sb.busy_vec, busy);
    chk({tag, ".outstanding"}, 32'(sb.outstanding), outs);
    chk({tag, ".err"}, 32'(sb.err), e);
  endtask

  initial begin
    idle();
    rst = 1;
    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      sb.id_valid = 1'($urandom); sb.id_rs1 = 5'($urandom); sb.id_rs2 = 5'($urandom);
      sb.id_rs1_used = 1'($urandom); sb.id_rs2_used = 1'($urandom); sb.id_rd = 5'($urandom);
      sb.id_rd_we = 1'($urandom); sb.id_long = 1'($urandom); sb.flush = 1'($urandom);
      sb.wb_valid = 1'($urandom); sb.wb_rd = 5'($urandom);
      tick();
    end
    state("reset", 32'h0, 0, 0);
    chk("reset.stall_cycles", sb.stall_cycles, 32'd0);
    rst = 0;
    idle();
    tick();

    // RAW on x5, released by a same-cycle writeback.
    issue(5'd5, 1'b1); #1;
    chk("raw.issue_fire", 32'(sb.issue_fire), 1);
    tick();
    state("raw.set", 32'h20, 1, 0);
    issue(5'd6, 1'b0); sb.id_rs1 = 5'd5; sb.id_rs1_used = 1; #1;
    chk("raw.stall0", 32'(sb.stall), 1);
    chk("raw.fire0", 32'(sb.issue_fire), 0);
    tick();
    chk("raw.stall1", 32'(sb.stall), 1);
    tick();
    sb.wb_valid = 1; sb.wb_rd = 5'd5; #1;
    chk("raw.wb_stall", 32'(sb.stall), 0);
    chk("raw.wb_fire", 32'(sb.issue_fire), 1);
    tick();
    idle();
    state("raw.clear", 32'h0, 0, 0);

    // WAW on x7 coinciding with its writeback: the set wins and the count is unchanged.
    issue(5'd7, 1'b1);
    tick();
    state("waw.set", 32'h80, 1, 0);
    issue(5'd7, 1'b1); sb.wb_valid = 1; sb.wb_rd = 5'd7; #1;
    chk("waw.fire", 32'(sb.issue_fire), 1);
    tick();
    state("waw.setwins", 32'h80, 1, 0);
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd7;
    tick();
    idle();
    state("waw.drain", 32'h0, 0, 0);

    // Outstanding budget of four.
    for (int r = 1; r <= 4; r++) begin
      issue(5'(r), 1'b1);
      tick();
    end
    state("budget.fill", 32'h1E, 4, 0);
    issue(5'd9, 1'b0); #1;
    chk("budget.short_fire", 32'(sb.issue_fire), 1);
    tick();
    state("budget.short", 32'h1E, 4, 0);
    issue(5'd9, 1'b1); sb.wb_valid = 1; sb.wb_rd = 5'd1; #1;
    chk("budget.full_stall", 32'(sb.stall), 1);
    chk("budget.full_fire", 32'(sb.issue_fire), 0);
    tick();
    state("budget.wb", 32'h1C, 3, 0);
    for (int r = 2; r <= 4; r++) begin
      idle(); sb.wb_valid = 1; sb.wb_rd = 5'(r);
      tick();
    end
    idle();
    state("budget.drain", 32'h0, 0, 0);

    // A long op to x0 counts without a busy bit, and a flushed hazarding op changes nothing.
    issue(5'd0, 1'b1); #1;
    chk("x0.fire", 32'(sb.issue_fire), 1);
    tick();
    state("x0.state", 32'h0, 1, 0);
    issue(5'd10, 1'b1);
    tick();
    state("flush.pre", 32'h400, 2, 0);
    issue(5'd11, 1'b1); sb.id_rs1 = 5'd10; sb.id_rs1_used = 1; sb.flush = 1; #1;
    chk("flush.stall", 32'(sb.stall), 0);
    chk("flush.fire", 32'(sb.issue_fire), 0);
    tick();
    state("flush.state", 32'h400, 2, 0);
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd10;
    tick();
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd0;
    tick();
    idle();
    state("x0.drain", 32'h0, 0, 0);

    // Underflow raises a sticky error, and the count saturates at zero.
    sb.wb_valid = 1; sb.wb_rd = 5'd0;
    tick();
    idle();
    state("err.underflow", 32'h0, 0, 1);
    tick();
    chk("err.sticky", 32'(sb.err), 1);

    // Writeback to a register that is not busy is an error; then three stall cycles feed the stats.
    rst = 1;
    tick();
    rst = 0;
    state("err.reset", 32'h0, 0, 0);
    issue(5'd3, 1'b1);
    tick();
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd8;
    tick();
    idle();
    state("err.stray_wb", 32'h08, 0, 1);
    sb.id_valid = 1; sb.id_rs2 = 5'd3; sb.id_rs2_used = 1;
    for (int i = 0; i < 3; i++) tick();
    idle();
    tick();
    chk("stats.stall_cycles", sb.stall_cycles, EXP_STALLS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
